// File: rtl/act_timeout_if.sv
// act_timeout_if: channel bus for act_timeout; warn_o exists only with ACT_TIMEOUT_WARN_EN
interface act_timeout_if #(
    parameter int CH = 2,
    parameter int CNT_W = 15
);
    logic [CH-1:0]       enable_i;
    logic [CH-1:0]       event_i;
    logic [CH*CNT_W-1:0] thr_i;
    logic [CH-1:0]       timeout_o;
    logic [CH-1:0]       expire_o;
    logic [CH*CNT_W-1:0] elapsed_o;
`ifdef ACT_TIMEOUT_WARN_EN
    logic [CH-1:0]       warn_o;
    modport master (output enable_i, event_i, thr_i, input timeout_o, expire_o, elapsed_o, warn_o);
    modport slave (input enable_i, event_i, thr_i, output timeout_o, expire_o, elapsed_o, warn_o);
`else
    modport master (output enable_i, event_i, thr_i, input timeout_o, expire_o, elapsed_o);
    modport slave (input enable_i, event_i, thr_i, output timeout_o, expire_o, elapsed_o);
`endif
endinterface

// File: rtl/act_timeout.sv
// act_timeout: independent per-channel activity timeouts on a prescaled tick; ACT_TIMEOUT_WARN_EN adds warn_o
module act_timeout #(
    parameter int CH = 2,
    parameter int TICK_DIV = 27000,
    parameter int CNT_W = 15
`ifdef ACT_TIMEOUT_WARN_EN
    ,
    parameter int WARN_TICKS = 1000
`endif
) (
    input logic          clk27,
    input logic          reset_n,
    act_timeout_if.slave bus
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
    for (genvar k = 0; k < CH; k++) begin : g_ch
        state_t           state_q, state_d;
        logic [PW-1:0]    presc_q, presc_d;
        logic [CNT_W-1:0] elapsed_q, elapsed_d, thr;
        logic             ev_prev_q, ev_prev_d, timeout_q, timeout_d, expire_q, expire_d;
        logic             en, ev, tick, cmp;
        assign thr = bus.thr_i[k*CNT_W +: CNT_W];
        assign en  = bus.enable_i[k];
        // an event wins over a coincident tick, so the count restarts at 0
        always_comb begin
            ev        = bus.event_i[k] ^ ev_prev_q;
            ev_prev_d = bus.event_i[k];
            tick      = presc_q == PW'(TICK_DIV - 1);
            cmp       = thr != '0 && elapsed_q >= thr;
            presc_d   = (!en || ev || tick) ? '0 : presc_q + 1'b1;
            elapsed_d = (!en || ev) ? '0 : (tick && elapsed_q != '1) ? elapsed_q + 1'b1 : elapsed_q;
            state_d   = !en ? IDLE : cmp ? EXPIRED : RUN;
            timeout_d = state_d == EXPIRED;
            expire_d  = state_d == EXPIRED && state_q != EXPIRED;
        end
        always_ff @(posedge clk27) begin
            if (!reset_n) begin
                state_q   <= IDLE;
                presc_q   <= '0;
                elapsed_q <= '0;
                ev_prev_q <= 1'b0;
                timeout_q <= 1'b0;
                expire_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                presc_q   <= presc_d;
                elapsed_q <= elapsed_d;
                ev_prev_q <= ev_prev_d;
                timeout_q <= timeout_d;
                expire_q  <= expire_d;
            end
        end
        assign bus.timeout_o[k]                 = timeout_q;
        assign bus.expire_o[k]                  = expire_q;
        assign bus.elapsed_o[k*CNT_W +: CNT_W]  = elapsed_q;
`ifdef ACT_TIMEOUT_WARN_EN
        localparam logic [CNT_W:0] WT = (CNT_W + 1)'(WARN_TICKS);
        logic warn_q, warn_d;
        always_comb warn_d = en && thr != '0 && ({1'b0, elapsed_q} + WT) >= {1'b0, thr} && !cmp;
        always_ff @(posedge clk27) begin
            if (!reset_n) warn_q <= 1'b0;
            else warn_q <= warn_d;
        end
        assign bus.warn_o[k] = warn_q;
`endif
    end
endmodule

// File: tb/tb_act_timeout.sv
// tb_act_timeout: table vectors, corner sequences and random stimulus against a tick-arithmetic model
module tb_act_timeout;
    localparam int CH = 2, TD = 4, CW = 8, MAXV = 255;
`ifdef ACT_TIMEOUT_WARN_EN
    localparam int WT = 2;
`endif
    logic clk27 = 1'b0;
    logic reset_n = 1'b0;
    act_timeout_if #(.CH(CH), .CNT_W(CW)) bus ();
    act_timeout #(
        .CH(CH),
        .TICK_DIV(TD),
`ifdef ACT_TIMEOUT_WARN_EN
        .WARN_TICKS(WT),
`endif
        .CNT_W(CW)
    ) dut (
        .clk27(clk27),
        .reset_n(reset_n),
        .bus(bus)
    );
    always #5 clk27 = ~clk27;

    int   checks = 0, errors = 0;
    int   m_run[CH], m_el[CH];
    logic m_to[CH], m_ex[CH], m_wn[CH], m_prev[CH];

    typedef struct {
        logic       rst_n;
        logic [1:0] en, ev;
        logic [7:0] thr0, thr1;
        int         cyc;
        logic [7:0] el0, el1;
        logic [1:0] to, ex;
    } vec_t;
    vec_t tbl[24];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // elapsed is simply the number of whole tick periods since the last restart, saturated
    task automatic predict();
        int   thr;
        logic en, cmp;
        for (int k = 0; k < CH; k++) begin
            thr = int'(bus.thr_i[k*CW +: CW]);
            en  = bus.enable_i[k];
            if (!reset_n) begin
                m_run[k] = 0; m_el[k] = 0; m_to[k] = 0; m_ex[k] = 0; m_wn[k] = 0; m_prev[k] = 0;
            end else begin
                cmp     = en && thr != 0 && m_el[k] >= thr;
                m_ex[k] = cmp && !m_to[k];
                m_to[k] = cmp;
`ifdef ACT_TIMEOUT_WARN_EN
                m_wn[k] = en && thr != 0 && m_el[k] + WT >= thr && !cmp;
`endif
                m_run[k]  = (!en || (bus.event_i[k] ^ m_prev[k])) ? 0 : (m_run[k] < 100000 ? m_run[k] + 1 : m_run[k]);
                m_prev[k] = bus.event_i[k];
                m_el[k]   = (m_run[k] / TD > MAXV) ? MAXV : m_run[k] / TD;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < CH; k++) begin
            chk($sformatf("model ch%0d elapsed", k), 32'(bus.elapsed_o[k*CW +: CW]), m_el[k]);
            chk($sformatf("model ch%0d timeout", k), 32'(bus.timeout_o[k]), 32'(m_to[k]));
            chk($sformatf("model ch%0d expire", k), 32'(bus.expire_o[k]), 32'(m_ex[k]));
`ifdef ACT_TIMEOUT_WARN_EN
            chk($sformatf("model ch%0d warn", k), 32'(bus.warn_o[k]), 32'(m_wn[k]));
`endif
        end
    endtask

    task automatic step();
        predict();
        @(posedge clk27);
        #1;
        check_model();
    endtask

    initial begin
        int pulses, hi;
        logic [1:0] en_r, ev_r;
        logic [7:0] t0, t1;
        for (int k = 0; k < CH; k++) begin
            m_run[k] = 0; m_el[k] = 0; m_to[k] = 0; m_ex[k] = 0; m_wn[k] = 0; m_prev[k] = 0;
        end
        //         rst  en     ev     thr0 thr1 cyc   el0 el1 to     ex
        tbl[0]  = '{1'b0, 2'b00, 2'b00, 5,   0,   2,    0,  0,  2'b00, 2'b00};
        tbl[1]  = '{1'b1, 2'b01, 2'b00, 5,   0,   19,   4,  0,  2'b00, 2'b00};
        tbl[2]  = '{1'b1, 2'b01, 2'b00, 5,   0,   1,    5,  0,  2'b00, 2'b00};
        tbl[3]  = '{1'b1, 2'b01, 2'b00, 5,   0,   1,    5,  0,  2'b01, 2'b01};
        tbl[4]  = '{1'b1, 2'b01, 2'b00, 5,   0,   1,    5,  0,  2'b01, 2'b00};
        tbl[5]  = '{1'b1, 2'b01, 2'b01, 5,   0,   1,    0,  0,  2'b01, 2'b00};
        tbl[6]  = '{1'b1, 2'b01, 2'b01, 5,   0,   1,    0,  0,  2'b00, 2'b00};
        tbl[7]  = '{1'b1, 2'b01, 2'b01, 5,   0,   14,   3,  0,  2'b00, 2'b00};
        tbl[8]  = '{1'b1, 2'b01, 2'b00, 5,   0,   1,    0,  0,  2'b00, 2'b00};
        tbl[9]  = '{1'b1, 2'b01, 2'b00, 5,   0,   3,    0,  0,  2'b00, 2'b00};
        tbl[10] = '{1'b1, 2'b01, 2'b00, 5,   0,   1,    1,  0,  2'b00, 2'b00};
        tbl[11] = '{1'b1, 2'b01, 2'b00, 0,   0,   2000, 255, 0, 2'b00, 2'b00};
        tbl[12] = '{1'b1, 2'b01, 2'b00, 200, 0,   1,    255, 0, 2'b01, 2'b01};
        tbl[13] = '{1'b1, 2'b01, 2'b00, 200, 0,   1,    255, 0, 2'b01, 2'b00};
        tbl[14] = '{1'b1, 2'b01, 2'b01, 200, 0,   1,    0,  0,  2'b01, 2'b00};
        tbl[15] = '{1'b1, 2'b01, 2'b01, 200, 0,   13,   3,  0,  2'b00, 2'b00};
        tbl[16] = '{1'b0, 2'b01, 2'b01, 200, 0,   1,    0,  0,  2'b00, 2'b00};
        tbl[17] = '{1'b1, 2'b01, 2'b01, 200, 0,   1,    0,  0,  2'b00, 2'b00};
        tbl[18] = '{1'b1, 2'b01, 2'b01, 200, 0,   4,    1,  0,  2'b00, 2'b00};
        tbl[19] = '{1'b1, 2'b11, 2'b01, 200, 3,   12,   4,  3,  2'b00, 2'b00};
        tbl[20] = '{1'b1, 2'b11, 2'b01, 200, 3,   1,    4,  3,  2'b10, 2'b10};
        tbl[21] = '{1'b1, 2'b01, 2'b01, 200, 3,   1,    4,  0,  2'b00, 2'b00};
        tbl[22] = '{1'b1, 2'b01, 2'b01, 4,   3,   1,    4,  0,  2'b01, 2'b01};
        tbl[23] = '{1'b1, 2'b01, 2'b01, 10,  3,   1,    5,  0,  2'b00, 2'b00};
        for (int i = 0; i < 24; i++) begin
            reset_n      = tbl[i].rst_n;
            bus.enable_i = tbl[i].en;
            bus.event_i  = tbl[i].ev;
            bus.thr_i    = {tbl[i].thr1, tbl[i].thr0};
            repeat (tbl[i].cyc) step();
            chk($sformatf("row%0d elapsed0", i), 32'(bus.elapsed_o[CW-1:0]), 32'(tbl[i].el0));
            chk($sformatf("row%0d elapsed1", i), 32'(bus.elapsed_o[2*CW-1:CW]), 32'(tbl[i].el1));
            chk($sformatf("row%0d timeout", i), 32'(bus.timeout_o), 32'(tbl[i].to));
            chk($sformatf("row%0d expire", i), 32'(bus.expire_o), 32'(tbl[i].ex));
        end
        // lowering the threshold below elapsed: one expire pulse, level held for the whole stretch
        bus.thr_i = {8'd3, 8'd3};
        pulses = 0;
        hi = 0;
        repeat (60) begin
            step();
            pulses += int'(bus.expire_o[0]);
            hi += int'(bus.timeout_o[0]);
        end
        chk("hold expire pulses", pulses, 1);
        chk("hold timeout cycles", hi, 60);
        // reset mid-count, then counting restarts from zero
        reset_n = 1'b0;
        step();
        chk("reset elapsed", 32'(bus.elapsed_o), 0);
        reset_n = 1'b1;
        bus.event_i = 2'b00;
        repeat (8) step();
        chk("restart elapsed0", 32'(bus.elapsed_o[CW-1:0]), 2);
        en_r = 2'b11;
        ev_r = 2'b00;
        t0 = 8'd5;
        t1 = 8'd7;
        repeat (3000) begin
            reset_n = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, 59) == 0) en_r[k] = ~en_r[k];
                if ($urandom_range(0, 24) == 0) ev_r[k] = ~ev_r[k];
            end
            if ($urandom_range(0, 39) == 0) t0 = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 39) == 0) t1 = 8'($urandom_range(0, 12));
            bus.enable_i = en_r;
            bus.event_i  = ev_r;
            bus.thr_i    = {t1, t0};
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
